// File: rtl/bird_sprite_renderer.sv
// Bird sprite renderer: accepts a new bird y over valid/ready and streams pixel
// writes to the VGA adapter, erasing the old sprite before drawing the new one.
module bird_sprite_renderer #(
    parameter int unsigned BIRD_X      = 20,
    parameter int unsigned SIZE        = 4,
    parameter int unsigned X_W         = 8,
    parameter int unsigned Y_W         = 7,
    parameter int unsigned SCREEN_H    = 120,
    parameter logic [2:0]  BG_COLOUR   = 3'b000,
    parameter logic [2:0]  BIRD_COLOUR = 3'b010
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           pos_valid,
    input  logic [Y_W-1:0] pos_y,
    output logic           pos_ready,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [2:0]     colour,
    output logic           plot,
    output logic           frame_done
);

    localparam int unsigned HALF_W = $clog2(SIZE);
    localparam int unsigned CNT_W  = 2 * HALF_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [Y_W-1:0]   prev_y_q;
    logic [Y_W-1:0]   new_y_q;
    logic             have_prev_q;
    logic             pos_ready_q;
    logic [X_W-1:0]   x_out_q;
    logic [Y_W-1:0]   y_out_q;
    logic [2:0]       colour_q;
    logic             plot_q;
    logic             frame_done_q;

    logic [Y_W-1:0]   base_y;
    logic [Y_W:0]     y_ext;
    logic [X_W-1:0]   x_d;
    logic [Y_W-1:0]   y_d;
    logic [2:0]       colour_d;
    logic             plot_d;
    logic             cnt_last;

    // Pixel for the current count: column-major walk, y widened one bit for clipping
    always_comb begin
        base_y   = (state_q == ERASE) ? prev_y_q : new_y_q;
        y_ext    = {1'b0, base_y} + (Y_W+1)'(cnt_q[HALF_W-1:0]);
        x_d      = X_W'(BIRD_X) + X_W'(cnt_q[CNT_W-1:HALF_W]);
        y_d      = Y_W'(y_ext);
        colour_d = (state_q == ERASE) ? BG_COLOUR : BIRD_COLOUR;
        plot_d   = (y_ext < (Y_W+1)'(SCREEN_H));
        cnt_last = (cnt_q == '1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            prev_y_q     <= '0;
            new_y_q      <= '0;
            have_prev_q  <= 1'b0;
            pos_ready_q  <= 1'b1;
            x_out_q      <= '0;
            y_out_q      <= '0;
            colour_q     <= BG_COLOUR;
            plot_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            plot_q       <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    pos_ready_q <= 1'b1;
                    if (pos_valid && pos_ready_q) begin
                        new_y_q     <= pos_y;
                        pos_ready_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= (have_prev_q && (pos_y != prev_y_q)) ? ERASE : DRAW;
                    end
                end
                ERASE, DRAW: begin
                    x_out_q  <= x_d;
                    y_out_q  <= y_d;
                    colour_q <= colour_d;
                    plot_q   <= plot_d;
                    cnt_q    <= cnt_q + 1'b1;
                    // Counter wraps to zero on the last pixel, ready for the next phase
                    if (cnt_last) begin
                        if (state_q == ERASE) begin
                            state_q <= DRAW;
                        end else begin
                            prev_y_q    <= new_y_q;
                            have_prev_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    frame_done_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pos_ready  = pos_ready_q;
    assign x_out      = x_out_q;
    assign y_out      = y_out_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bird_sprite_renderer.sv
// Bench for bird_sprite_renderer: table of directed updates, randomized updates
// against a pixel-list model, and reset/hold corner sequences.
module tb_bird_sprite_renderer;

    logic       clk;
    logic       resetn;
    logic       pos_valid;
    logic [6:0] pos_y;
    logic       pos_ready;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       plot;
    logic       frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] model_prev      = 7'd0;
    bit         model_have_prev = 1'b0;

    bird_sprite_renderer dut (
        .clk       (clk),
        .resetn    (resetn),
        .pos_valid (pos_valid),
        .pos_y     (pos_y),
        .pos_ready (pos_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .colour    (colour),
        .plot      (plot),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output snapshot; x/y only matter when the pixel is actually plotted
    function automatic logic [31:0] pack(input logic rdy, input logic fd, input logic pl,
                                         input logic [2:0] c, input logic [7:0] x,
                                         input logic [6:0] yy);
        return {11'd0, rdy, fd, pl, c, (pl === 1'b1) ? x : 8'd0, (pl === 1'b1) ? yy : 7'd0};
    endfunction

    // Offer one update and check every following cycle against the model pixel list
    task automatic render(input logic [6:0] y, input bit hold, output int fd_cycle, output int n_plot);
        logic [31:0] exp_q[$];
        int          guard;
        int          cyc;
        int          base;
        bit          erase;
        logic [2:0]  col;
        erase = model_have_prev && (y != model_prev);
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 0 && !erase) continue;
            base = (ph == 0) ? int'(model_prev) : int'(y);
            col  = (ph == 0) ? 3'b000 : 3'b010;
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    exp_q.push_back(pack(1'b0, 1'b0, (base + r) < 120, col,
                                         8'(20 + c), 7'(base + r)));
        end
        fd_cycle = 0;
        n_plot   = 0;
        guard    = 0;
        while (pos_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("ready_before_offer", {31'd0, pos_ready}, 32'd1);
        pos_valid = 1'b1;
        pos_y     = y;
        @(posedge clk); #1;
        if (!hold) pos_valid = 1'b0;
        cyc = 0;
        while (cyc < 60) begin
            if (hold) pos_y = 7'($urandom);
            @(posedge clk); #1;
            cyc++;
            if (frame_done === 1'b1) break;
            if (plot === 1'b1) n_plot++;
            if (cyc <= exp_q.size())
                chk($sformatf("pixel%0d_y%0d", cyc, y),
                    pack(pos_ready, frame_done, plot, colour, x_out, y_out), exp_q[cyc-1]);
        end
        fd_cycle = cyc;
        chk("fd_cycle_model", 32'(fd_cycle), 32'(exp_q.size() + 1));
        chk("done_cycle_outputs", pack(pos_ready, frame_done, plot, 3'd0, 8'd0, 7'd0),
            pack(1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 7'd0));
        @(posedge clk); #1;
        pos_valid = 1'b0;
        chk("ready_after_done", {30'd0, pos_ready, frame_done}, 32'b10);
        model_prev      = y;
        model_have_prev = 1'b1;
    endtask

    typedef struct {
        logic [6:0] y;
        int         fd;
        int         np;
    } vec_t;

    initial begin
        vec_t       vecs[7];
        int         fd;
        int         np;
        logic [6:0] ry;
        int         erase_n;

        vecs[0] = '{7'd50,  17, 16};
        vecs[1] = '{7'd46,  33, 32};
        vecs[2] = '{7'd46,  17, 16};
        vecs[3] = '{7'd118, 33, 24};
        vecs[4] = '{7'd127, 33, 8};
        vecs[5] = '{7'd0,   33, 16};
        vecs[6] = '{7'd119, 33, 20};

        resetn    = 1'b0;
        pos_valid = 1'b0;
        pos_y     = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", pack(pos_ready, frame_done, plot, colour, 8'd0, 7'd0),
            pack(1'b1, 1'b0, 1'b0, 3'b000, 8'd0, 7'd0));
        chk("reset_xy", {17'd0, x_out, y_out}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            render(vecs[i].y, 1'b0, fd, np);
            chk($sformatf("tbl%0d_fd", i), 32'(fd), 32'(vecs[i].fd));
            chk($sformatf("tbl%0d_nplot", i), 32'(np), 32'(vecs[i].np));
        end

        // Producer holds valid and wiggles y while the block is busy
        render(7'd30, 1'b1, fd, np);
        chk("hold_fd", 32'(fd), 32'd33);

        for (int i = 0; i < 25; i++) begin
            ry = ($urandom_range(0, 3) == 0) ? model_prev : 7'($urandom_range(0, 127));
            render(ry, 1'($urandom_range(0, 1)), fd, np);
        end

        // Reset in the middle of the draw phase
        ry      = (model_prev == 7'd60) ? 7'd61 : 7'd60;
        erase_n = (model_have_prev && ry != model_prev) ? 16 : 0;
        pos_valid = 1'b1;
        pos_y     = ry;
        @(posedge clk); #1;
        pos_valid = 1'b0;
        repeat (erase_n + 8) @(posedge clk);
        #1;
        chk("pre_reset_pixel7", pack(1'b0, 1'b0, plot, colour, x_out, y_out),
            pack(1'b0, 1'b0, 1'b1, 3'b010, 8'd21, 7'(ry + 7'd3)));
        resetn    = 1'b0;
        pos_valid = 1'b1;
        pos_y     = 7'd99;
        @(posedge clk); #1;
        chk("mid_reset_ctl", pack(pos_ready, frame_done, plot, colour, 8'd0, 7'd0),
            pack(1'b1, 1'b0, 1'b0, 3'b000, 8'd0, 7'd0));
        chk("mid_reset_xy", {17'd0, x_out, y_out}, 32'd0);
        @(posedge clk); #1;
        resetn    = 1'b1;
        pos_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("no_latch_in_reset", {29'd0, plot, frame_done, pos_ready}, 32'b001);
        model_have_prev = 1'b0;
        render(7'd10, 1'b0, fd, np);
        chk("post_reset_fd", 32'(fd), 32'd17);
        chk("post_reset_nplot", 32'(np), 32'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
